ssd_display_arbiter: RTL
========================

// Module: ssd_display_arbiter
// PURPOSE
//  Shares the 4-digit seven-segment display between N_REQ requesters (mode, brightness,
//  alert, ...). Picks one owner by round-robin and guarantees it a minimum hold time
//  before any other requester can take over. Registers the owner's four BCD digits and
//  drives them to the display multiplexer's digit inputs.
//  The multiplexer forces its anodes to 4'b1111 whenever o_blank is high.
// PARAMETERS
//  N_REQ        3            number of requesters (2..8)
//  HOLD_CYCLES  100_000_000  minimum ownership in i_clk cycles (1 s at 100 MHz), >=2
//  CNT_W        27           hold/blink counter width, must hold HOLD_CYCLES-1
//  BLINK_CYCLES 25_000_000   blink half-period in cycles (used only with SSD_ARB_BLINK_EN)
// PORTS
//  i_clk    in   1         system clock; the only clock
//  i_rst_n  in   1         reset, synchronous, active-low
//  i_req    in   N_REQ     level request; bit k = requester k wants the display
//  i_data   in   16*N_REQ  packed digits; requester k at [16k+15:16k], nibble 0 = d0 (rightmost)
//  o_gnt    out  N_REQ     one-hot current owner; all zero when idle
//  o_d0..3  out  4 each    registered digits of the owner, to the multiplexer's d0..d3
//  o_blank  out  1         1 = display dark
//  o_busy   out  1         1 = an owner is granted
// BEHAVIOUR
//  - Reset (i_rst_n low at a clock edge): o_gnt=0, o_d0..o_d3=0, o_blank=1, o_busy=0.
//    Round-robin pointer=0, hold counter=0, FSM=IDLE.
//  - Reset mid-ownership aborts the owner immediately; no state survives it.
//  - FSM states IDLE and OWN.
//  - IDLE: at an edge with any i_req bit set, grant the first set bit at or after the
//    pointer (wrapping). Go to OWN and clear the counter.
//  - OWN: the counter increments every cycle while the owner's i_req stays high.
//    The hold expires when counter==HOLD_CYCLES-1.
//  - Owner drops i_req:
//    - another request pending: grant the next by round-robin at the same edge (no gap);
//    - none pending: return to IDLE, o_gnt=0.
//  - Hold expires while another requester is pending: grant the next requester after the
//    owner (round-robin) at the same edge, counter=0. The display has no dark cycle.
//  - Hold expires while the owner is the sole requester: the owner keeps the grant,
//    counter=0.
//  - Before expiry the owner is never preempted, whatever other requests arrive.
//  - On each grant the pointer is set to owner+1 mod N_REQ.
//  - Latency: a request seen at edge t gives o_gnt and o_d* valid after edge t
//    (registered, 1 cycle).
//  - Digit updates: while owning, o_d* re-register i_data[owner] every cycle, so owner
//    digit updates are visible 1 cycle later.
//  - Grant switch: o_d* switch to the new owner's data on the same edge as o_gnt.
//  - Idle: o_d* hold their last values.
//  - o_busy = |o_gnt. o_blank = ~o_busy unless modified by SSD_ARB_BLINK_EN.
//  - Simultaneous request and drop of different bits in one cycle: decided from that
//    cycle's i_req only.
//  - Bits of i_req above N_REQ do not exist. Illegal parameter values are not checked.
// CONFIGURATION
//  - SSD_ARB_BLINK_EN defined: requester N_REQ-1 is the alert source.
//    - While it owns the display, o_blank toggles every BLINK_CYCLES, starting dark=0
//      on the grant edge.
//    - The blink counter is independent of the hold counter.
//    - On leaving ownership the blink counter clears and o_blank=~o_busy.
//  - SSD_ARB_BLINK_EN undefined: no blink logic; o_blank=~o_busy always; BLINK_CYCLES
//    is ignored.
// TESTING  (N_REQ=3, HOLD_CYCLES=8, BLINK_CYCLES=4)
//  1. i_rst_n=0 for 3 cycles with i_req=3'b111 -> o_gnt=0, o_d*=0, o_blank=1, o_busy=0.
//     After release, o_gnt=001 one cycle later.
//  2. i_req=001, i_data[15:0]=16'h1234 at edge t -> after t: o_gnt=001,
//     o_d0=4, o_d1=3, o_d2=2, o_d3=1, o_blank=0.
//  3. i_req=011 held steady -> o_gnt alternates 001/010 every 8 cycles with no zero cycle.
//     o_d* follow each owner's data.
//  4. Owner 0 drops i_req on hold cycle 3 while req2 is pending -> o_gnt=100 next edge.
//     With nothing pending -> o_gnt=000, o_blank=1 next edge.
//  5. Sole requester 1 held 20 cycles -> o_gnt=010 throughout.
//     Changing i_data[31:16] to 16'h0009 mid-hold -> o_d0=9 one cycle later.
//  6. With SSD_ARB_BLINK_EN, requester 2 granted -> o_blank pattern 0000 1111 0000 ...
//     When requester 2 drops, o_blank=1 if idle.

Source files
------------

// File: rtl/ssd_display_arbiter.sv
// rtl/ssd_display_arbiter.sv - round-robin owner arbitration of the 4-digit seven-segment display
// Optional alert blink on requester N_REQ-1 when SSD_ARB_BLINK_EN is defined.
module ssd_display_arbiter #(
  parameter int N_REQ        = 3,
  parameter int HOLD_CYCLES  = 100_000_000,
  parameter int CNT_W        = 27,
  parameter int BLINK_CYCLES = 25_000_000
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [N_REQ-1:0]     i_req,
  input  logic [16*N_REQ-1:0]  i_data,
  output logic [N_REQ-1:0]     o_gnt,
  output logic [3:0]           o_d0,
  output logic [3:0]           o_d1,
  output logic [3:0]           o_d2,
  output logic [3:0]           o_d3,
  output logic                 o_blank,
  output logic                 o_busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t            state, next_state;
  logic [IDX_W-1:0]  owner, next_owner;
  logic [IDX_W-1:0]  ptr, next_ptr;
  logic [CNT_W-1:0]  cnt, next_cnt;
  logic [N_REQ-1:0]  owner_mask;
  logic [N_REQ-1:0]  others;
  logic              take_grant;
  logic [15:0]       digits;

  // First set bit of mask at or after start, wrapping around.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] mask,
                                               input logic [IDX_W-1:0] start);
    logic [IDX_W-1:0] pick;
    logic             found;
    int               k;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      k = int'(start) + i;
      if (k >= N_REQ) k = k - N_REQ;
      if (!found && mask[k]) begin
        pick  = IDX_W'(k);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
  endfunction

  assign owner_mask = N_REQ'(1) << owner;
  assign others     = i_req & ~owner_mask;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
      owner <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= next_state;
      owner <= next_owner;
      ptr   <= next_ptr;
      cnt   <= next_cnt;
    end
  end

  // ptr always equals owner+1 while owning, so it doubles as the "after owner" start.
  always_comb begin
    next_state = state;
    next_owner = owner;
    next_ptr   = ptr;
    next_cnt   = cnt;
    take_grant = 1'b0;
    case (state)
      IDLE: begin
        if (|i_req) begin
          next_state = OWN;
          next_owner = rr_pick(i_req, ptr);
          take_grant = 1'b1;
        end
      end
      OWN: begin
        if (!i_req[owner]) begin
          next_cnt = '0;
          if (|i_req) begin
            next_owner = rr_pick(i_req, ptr);
            take_grant = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end else if (cnt == HOLD_LAST) begin
          next_cnt = '0;
          if (|others) begin
            next_owner = rr_pick(others, ptr);
            take_grant = 1'b1;
          end
        end else begin
          next_cnt = cnt + CNT_W'(1);
        end
      end
      default: next_state = IDLE;
    endcase
    if (take_grant) begin
      next_cnt = '0;
      next_ptr = wrap_inc(next_owner);
    end
  end

  // Digits follow whoever owns after this edge; they hold while idle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      digits <= '0;
    end else if (next_state == OWN) begin
      digits <= i_data[{next_owner, 4'b0000} +: 16];
    end
  end

  assign o_d0 = digits[3:0];
  assign o_d1 = digits[7:4];
  assign o_d2 = digits[11:8];
  assign o_d3 = digits[15:12];

`ifdef SSD_ARB_BLINK_EN
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_CYCLES - 1);

  logic [CNT_W-1:0] bcnt;
  logic             dark;
  logic             alert_next;

  assign alert_next = (next_state == OWN) && (next_owner == LAST_IDX);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || !alert_next || take_grant) begin
      bcnt <= '0;
      dark <= 1'b0;
    end else if (bcnt == BLINK_LAST) begin
      bcnt <= '0;
      dark <= ~dark;
    end else begin
      bcnt <= bcnt + CNT_W'(1);
    end
  end

  always_comb begin
    o_busy  = (state == OWN);
    o_gnt   = o_busy ? owner_mask : '0;
    o_blank = ~o_busy | dark;
  end
`else
  always_comb begin
    o_busy  = (state == OWN);
    o_gnt   = o_busy ? owner_mask : '0;
    o_blank = ~o_busy;
  end
`endif

endmodule
